// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory subsystem for the core's load/store port.
//
// Decodes the core's byte address into a local RAM, a small block of
// memory-mapped registers (TX byte FIFO data/status, a free-running cycle
// counter and an LED register), and an unmapped remainder that reports a
// sticky bus error. Load data is registered on the rising edge so the core
// can consume it before its falling-edge commit.
//
// Ports:
//   clock        block clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   dmemaddr     byte address from the core ALU
//   dmemdatain   store data
//   dmemop       access size: 000 b, 001 h, 010 w, 100 bu, 101 hu (others = w)
//   dmemwe       store enable
//   dmemdataout  registered load data
//   tx_data      TX FIFO head byte
//   tx_valid     TX FIFO non-empty
//   tx_ready     consumer accepts the head byte when tx_valid is also high
//   led          LED register
//   bus_err      sticky misaligned/unmapped access flag
module dmem_mmio #(
  parameter int RAM_AW  = 15,
  parameter int FIFO_AW = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic [31:0] dmemdataout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] led,
  output logic        bus_err
);

  localparam int RAM_WORDS  = 1 << (RAM_AW - 2);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_LED    = 2'd3;

  // Storage
  logic [31:0]        ram [RAM_WORDS];
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [31:0]        cycle_count;

  // Decode
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              is_unsigned;
  logic              misaligned;
  logic              ram_sel;
  logic              reg_sel;
  logic              access_err;
  logic [1:0]        reg_idx;
  logic [RAM_AW-3:0] word_idx;
  logic [3:0]        byte_en;
  logic [31:0]       store_word;

  // Read path
  logic [31:0] status_word;
  logic [31:0] reg_word;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // FIFO control
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_req;
  logic push_ok;
  logic ram_we;
  logic led_we;
  logic cycle_we;

  // Unlisted op codes behave as word accesses; only b/h carry a signedness bit.
  assign is_byte     = (dmemop == 3'b000) || (dmemop == 3'b100);
  assign is_half     = (dmemop == 3'b001) || (dmemop == 3'b101);
  assign is_word     = !is_byte && !is_half;
  assign is_unsigned = dmemop[2];

  // Misaligned accesses still proceed at the aligned-down address. Lane
  // selection below only looks at the address bits that remain meaningful
  // for each size, so the alignment happens implicitly.
  assign misaligned = (is_half && dmemaddr[0]) ||
                      (is_word && (dmemaddr[1:0] != 2'b00));

  assign ram_sel    = (dmemaddr[31:RAM_AW] == '0);
  assign reg_sel    = (dmemaddr[31:4] == 28'h800_0000);
  assign access_err = misaligned || (!ram_sel && !reg_sel);
  assign reg_idx    = dmemaddr[3:2];
  assign word_idx   = dmemaddr[RAM_AW-1:2];

  assign ram_we   = dmemwe && ram_sel;
  assign led_we   = dmemwe && reg_sel && (reg_idx == REG_LED);
  assign cycle_we = dmemwe && reg_sel && (reg_idx == REG_CYCLE);
  assign push_req = dmemwe && reg_sel && (reg_idx == REG_TXDATA);

  // Byte enables and lane-replicated store data for sb/sh/sw.
  always_comb begin
    byte_en    = 4'b1111;
    store_word = dmemdatain;
    if (is_byte) begin
      byte_en    = 4'b0001 << dmemaddr[1:0];
      store_word = {4{dmemdatain[7:0]}};
    end else if (is_half) begin
      byte_en    = dmemaddr[1] ? 4'b1100 : 4'b0011;
      store_word = {2{dmemdatain[15:0]}};
    end
  end

  // FIFO flags; count can reach DEPTH, so its top bit alone means full.
  assign fifo_full  = count[FIFO_AW];
  assign fifo_empty = (count == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = fifo_mem[rd_ptr];
  assign pop        = tx_valid && tx_ready;

  // A push into a full FIFO only succeeds when a pop frees a slot that edge.
  assign push_ok = push_req && (!fifo_full || pop);

  always_comb begin
    status_word                 = '0;
    status_word[0]              = fifo_full;
    status_word[1]              = fifo_empty;
    status_word[2]              = overflow;
    status_word[4+FIFO_AW:4]    = count;
  end

  always_comb begin
    reg_word = '0;
    case (reg_idx)
      REG_TXDATA: reg_word = '0;
      REG_STATUS: reg_word = status_word;
      REG_CYCLE:  reg_word = cycle_count;
      REG_LED:    reg_word = {16'h0000, led};
      default:    reg_word = '0;
    endcase
  end

  // Unmapped addresses read as zero, which also zeroes any extracted lane.
  always_comb begin
    rd_word = '0;
    if (ram_sel) begin
      rd_word = ram[word_idx];
    end else if (reg_sel) begin
      rd_word = reg_word;
    end
  end

  always_comb begin
    rd_byte = rd_word[7:0];
    case (dmemaddr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = dmemaddr[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = rd_word;
    if (is_byte) begin
      load_data = is_unsigned ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      load_data = is_unsigned ? {16'h0000, rd_half} : {{16{rd_half[15]}}, rd_half};
    end
  end

  // RAM contents survive reset; stores presented during reset are dropped.
  always_ff @(posedge clock) begin
    if (!reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[word_idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      fifo_mem[wr_ptr] <= dmemdatain[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      count <= count + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Load register, sticky bus error, LED and cycle counter. A CYCLE store
  // takes priority over the free-running increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmemdataout <= '0;
      bus_err     <= 1'b0;
      led         <= '0;
      cycle_count <= '0;
    end else begin
      dmemdataout <= load_data;
      if (access_err) begin
        bus_err <= 1'b1;
      end
      if (led_we) begin
        led <= dmemdatain[15:0];
      end
      if (cycle_we) begin
        cycle_count <= dmemdatain;
      end else begin
        cycle_count <= cycle_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: self-checking bench for dmem_mmio.
//
// A byte-array RAM, a queue-based TX FIFO and plain counters model the
// memory map. drive_cycle presents one bus cycle, advances the model by one
// clock edge and leaves the expected load value in exp_load; each test task
// compares the DUT against the model or against fixed vectors.
module tb_dmem_mmio;

  logic        clock;
  logic        reset;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic [31:0] dmemdataout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] led;
  logic        bus_err;

  int checks;
  int errors;

  // Reference model state
  logic [7:0]  m_ram [0:32767];
  logic [7:0]  q [$];
  logic        m_ovf;
  logic [31:0] m_cycle;
  logic [15:0] m_led;
  logic        m_err;
  logic [31:0] exp_load;

  dmem_mmio dut (
    .clock       (clock),
    .reset       (reset),
    .dmemaddr    (dmemaddr),
    .dmemdatain  (dmemdatain),
    .dmemop      (dmemop),
    .dmemwe      (dmemwe),
    .dmemdataout (dmemdataout),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .led         (led),
    .bus_err     (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One bus cycle: drive at the falling edge, update the model at the rising
  // edge, return 1 time unit later with outputs settled.
  task automatic drive_cycle(input bit rst, input logic [2:0] op, input logic [31:0] addr,
                             input bit we, input logic [31:0] data, input bit rdy);
    bit          is_b, is_h, is_w, mis, in_ram, in_reg, do_pop;
    logic [31:0] base, ha, w, ld;
    int          sz;
    @(negedge clock);
    reset = rst; dmemop = op; dmemaddr = addr; dmemwe = we; dmemdatain = data; tx_ready = rdy;
    is_b   = (op == 3'd0) || (op == 3'd4);
    is_h   = (op == 3'd1) || (op == 3'd5);
    is_w   = !is_b && !is_h;
    mis    = (is_h && (addr % 32'd2 != 0)) || (is_w && (addr % 32'd4 != 0));
    base   = addr - (addr % 32'd4);
    ha     = addr - (addr % 32'd2);
    in_ram = addr < 32'd32768;
    in_reg = (base >= 32'h8000_0000) && (base <= 32'h8000_000C);
    sz     = q.size();
    if (in_ram) w = {m_ram[base+3], m_ram[base+2], m_ram[base+1], m_ram[base]};
    else if (base == 32'h8000_0004)
      w = 32'((sz * 16) + (m_ovf ? 4 : 0) + (sz == 0 ? 2 : 0) + (sz == 8 ? 1 : 0));
    else if (base == 32'h8000_0008) w = m_cycle;
    else if (base == 32'h8000_000C) w = {16'h0000, m_led};
    else w = 32'h0;
    if (is_b) begin
      ld = (w >> (8 * (addr % 32'd4))) & 32'hFF;
      if (op == 3'd0 && ld[7]) ld = ld | 32'hFFFF_FF00;
    end else if (is_h) begin
      ld = (w >> ((addr % 32'd4 >= 2) ? 16 : 0)) & 32'hFFFF;
      if (op == 3'd1 && ld[15]) ld = ld | 32'hFFFF_0000;
    end else ld = w;
    @(posedge clock);
    if (rst) begin
      exp_load = 32'h0; q.delete(); m_ovf = 1'b0; m_cycle = 32'h0; m_led = 16'h0; m_err = 1'b0;
    end else begin
      exp_load = ld;
      if (mis || !(in_ram || in_reg)) m_err = 1'b1;
      do_pop = (sz > 0) && rdy;
      if (we && in_ram) begin
        if (is_b) m_ram[addr] = data[7:0];
        else if (is_h) begin m_ram[ha] = data[7:0]; m_ram[ha+1] = data[15:8]; end
        else for (int i = 0; i < 4; i++) m_ram[base+i] = data[8*i +: 8];
      end
      m_cycle = (we && base == 32'h8000_0008) ? data : m_cycle + 32'd1;
      if (we && base == 32'h8000_000C) m_led = data[15:0];
      if (do_pop) void'(q.pop_front());
      if (we && base == 32'h8000_0000) begin
        if (q.size() < 8) q.push_back(data[7:0]);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 3'd2, 32'h8000_0000, 1, 32'h33, 0);
    drive_cycle(1, 3'd2, 32'h8000_000C, 1, 32'h1234, 0);
    checks++; if (dmemdataout !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected %h", dmemdataout, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL reset_led: got %h expected 0000", led); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err); end
    drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h2) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", dmemdataout, 32'h2); end
    drive_cycle(0, 3'd2, 32'h8000_0008, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h1) begin errors++; $display("[TB] FAIL reset_cycle: got %h expected %h", dmemdataout, 32'h1); end
  endtask

  task automatic test_ram_random();
    logic [2:0]  ops [6];
    logic [2:0]  op;
    logic [31:0] a;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    for (int i = 0; i < 256; i += 4) drive_cycle(0, 3'd2, 32'(i), 1, $urandom, 0);
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = 32'($urandom_range(0, 255));
      if (op == 3'd1 || op == 3'd5) a = a & ~32'h1;
      else if (op != 3'd0 && op != 3'd4) a = a & ~32'h3;
      drive_cycle(0, op, a, bit'($urandom_range(0, 1)), $urandom, 0);
      checks++; if (dmemdataout !== exp_load) begin errors++; $display("[TB] FAIL ram_load op=%0d addr=%h: got %h expected %h", op, a, dmemdataout, exp_load); end
      checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL ram_bus_err addr=%h: got %b expected 0", a, bus_err); end
    end
  endtask

  task automatic test_spec_vectors();
    drive_cycle(0, 3'd2, 32'h10, 1, 32'h8899_AABB, 0);
    drive_cycle(0, 3'd0, 32'h11, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'hFFFF_FFAA) begin errors++; $display("[TB] FAIL lb_11: got %h expected %h", dmemdataout, 32'hFFFF_FFAA); end
    drive_cycle(0, 3'd4, 32'h13, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h0000_0088) begin errors++; $display("[TB] FAIL lbu_13: got %h expected %h", dmemdataout, 32'h88); end
    drive_cycle(0, 3'd1, 32'h12, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'hFFFF_8899) begin errors++; $display("[TB] FAIL lh_12: got %h expected %h", dmemdataout, 32'hFFFF_8899); end
    drive_cycle(0, 3'd5, 32'h10, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h0000_AABB) begin errors++; $display("[TB] FAIL lhu_10: got %h expected %h", dmemdataout, 32'hAABB); end
    drive_cycle(0, 3'd0, 32'h12, 1, 32'h55, 0);
    drive_cycle(0, 3'd2, 32'h10, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h8855_AABB) begin errors++; $display("[TB] FAIL sb_lw_10: got %h expected %h", dmemdataout, 32'h8855_AABB); end
  endtask

  task automatic test_cycle();
    logic [31:0] want [3];
    want = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    drive_cycle(0, 3'd2, 32'h8000_0008, 1, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 3'd2, 32'h8000_0008, 0, 32'h0, 0);
      checks++; if (dmemdataout !== want[i]) begin errors++; $display("[TB] FAIL cycle_read%0d: got %h expected %h", i, dmemdataout, want[i]); end
    end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL cycle_bus_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    d = $urandom;
    drive_cycle(0, 3'd2, 32'h8000_000C, 1, d, 0);
    checks++; if (led !== d[15:0]) begin errors++; $display("[TB] FAIL led_write: got %h expected %h", led, d[15:0]); end
    drive_cycle(0, 3'd2, 32'h8000_000C, 0, 32'h0, 0);
    checks++; if (dmemdataout !== {16'h0, d[15:0]}) begin errors++; $display("[TB] FAIL led_read: got %h expected %h", dmemdataout, {16'h0, d[15:0]}); end
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 9; i++) begin
      drive_cycle(0, 3'd0, 32'h8000_0000, 1, 32'h41 + 32'(i), 0);
      if (i == 0) begin
        checks++; if (dmemdataout !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected 0", dmemdataout); end
      end
    end
    drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h85) begin errors++; $display("[TB] FAIL status_full_ovf: got %h expected %h", dmemdataout, 32'h85); end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 0);
      checks++; if (tx_data !== 8'h41) begin errors++; $display("[TB] FAIL tx_stall%0d: got %h expected 41", i, tx_data); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 + 8'(i)) begin errors++; $display("[TB] FAIL drain%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, 8'h41 + 8'(i)); end
      drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 1);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", tx_valid); end
    drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, 1);
    checks++; if (dmemdataout !== 32'h06) begin errors++; $display("[TB] FAIL status_empty: got %h expected %h", dmemdataout, 32'h06); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] fill [8];
    logic [7:0] want;
    for (int i = 0; i < 8; i++) begin
      fill[i] = 8'($urandom);
      drive_cycle(0, 3'd2, 32'h8000_0000, 1, {24'h0, fill[i]}, 0);
    end
    drive_cycle(0, 3'd2, 32'h8000_0000, 1, 32'h5A, 1);
    drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, 0);
    checks++; if (dmemdataout !== 32'h85) begin errors++; $display("[TB] FAIL full_push_pop_status: got %h expected %h", dmemdataout, 32'h85); end
    for (int i = 0; i < 8; i++) begin
      want = (i < 7) ? fill[i+1] : 8'h5A;
      checks++; if (tx_valid !== 1'b1 || tx_data !== want) begin errors++; $display("[TB] FAIL full_drain%0d: got valid=%b data=%h expected data=%h", i, tx_valid, tx_data, want); end
      drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 1);
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain_empty: got %b expected 0", tx_valid); end
  endtask

  task automatic test_push_on_empty();
    drive_cycle(0, 3'd2, 32'h8000_0000, 1, 32'h77, 1);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("[TB] FAIL push_empty: got valid=%b data=%h expected valid=1 data=77", tx_valid, tx_data); end
    drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL push_empty_pop: got %b expected 0", tx_valid); end
  endtask

  task automatic test_fifo_random();
    logic [31:0] a;
    bit          rdy;
    for (int i = 0; i < 120; i++) begin
      rdy = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: drive_cycle(0, 3'd2, 32'h8000_0000, 1, $urandom, rdy);
        1: drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, rdy);
        2: begin
          a = 32'($urandom_range(0, 255)) & ~32'h3;
          drive_cycle(0, 3'd2, a, 0, 32'h0, rdy);
        end
        default: drive_cycle(0, 3'd2, 32'h8000_0000, 1, $urandom, 1);
      endcase
      checks++; if (dmemdataout !== exp_load) begin errors++; $display("[TB] FAIL mix_load%0d: got %h expected %h", i, dmemdataout, exp_load); end
      checks++; if (tx_valid !== (q.size() > 0)) begin errors++; $display("[TB] FAIL mix_valid%0d: got %b expected %b", i, tx_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (tx_data !== q[0]) begin errors++; $display("[TB] FAIL mix_data%0d: got %h expected %h", i, tx_data, q[0]); end
      end
    end
    checks++; if (bus_err !== m_err) begin errors++; $display("[TB] FAIL mix_bus_err: got %b expected %b", bus_err, m_err); end
  endtask

  task automatic test_errors();
    logic [31:0] want;
    drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 1);
    drive_cycle(0, 3'd2, 32'h4000_0000, 0, 32'h0, 1);
    checks++; if (dmemdataout !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_load: got %h expected 0", dmemdataout); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_bus_err: got %b expected 1", bus_err); end
    want = {m_ram[7], m_ram[6], m_ram[5], m_ram[4]};
    drive_cycle(0, 3'd2, 32'h6, 0, 32'h0, 1);
    checks++; if (dmemdataout !== want) begin errors++; $display("[TB] FAIL misaligned_load: got %h expected %h", dmemdataout, want); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_bus_err: got %b expected 1", bus_err); end
  endtask

  task automatic test_final_reset();
    drive_cycle(0, 3'd2, 32'h8000_000C, 1, 32'hBEEF, 0);
    drive_cycle(0, 3'd2, 32'h8000_0000, 1, 32'h99, 0);
    drive_cycle(0, 3'd2, 32'h8000_0000, 1, 32'h98, 0);
    checks++; if (led !== 16'hBEEF || tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: got led=%h valid=%b expected led=beef valid=1", led, tx_valid); end
    drive_cycle(0, 3'd2, 32'h0, 0, 32'h0, 1);
    drive_cycle(1, 3'd2, 32'h0, 0, 32'h0, 1);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL final_reset_bus_err: got %b expected 0", bus_err); end
    checks++; if (led !== 16'h0) begin errors++; $display("[TB] FAIL final_reset_led: got %h expected 0000", led); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL final_reset_tx_valid: got %b expected 0", tx_valid); end
    drive_cycle(0, 3'd2, 32'h8000_0004, 0, 32'h0, 1);
    checks++; if (dmemdataout !== 32'h2 || tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL final_status: got %h valid=%b expected 00000002 valid=0", dmemdataout, tx_valid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; dmemaddr = 32'h0; dmemdatain = 32'h0; dmemop = 3'd2; dmemwe = 1'b0; tx_ready = 1'b0;
    m_ovf = 1'b0; m_cycle = 32'h0; m_led = 16'h0; m_err = 1'b0; exp_load = 32'h0;
    $display("[TB] starting dmem_mmio bench");
    test_reset();
    test_ram_random();
    test_spec_vectors();
    test_cycle();
    test_led();
    test_fifo_overflow();
    test_full_push_pop();
    test_push_on_empty();
    test_fifo_random();
    test_errors();
    test_final_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
